// File: rtl/cache_ctrl_l1_assoc.sv
// L1 set-associative write-back, write-allocate cache controller with age-based LRU.
// One outstanding CPU request; line fills and write-backs go to a single lower-level port.
module cache_ctrl_l1_assoc #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned NUM_SETS       = 16,
    parameter int unsigned NUM_WAYS       = 2,
    parameter int unsigned PROC_ID_WIDTH  = 2,
    parameter int unsigned PROC_ID        = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 cpu_req_valid,
    input  logic                                 cpu_req_write,
    input  logic [ADDR_WIDTH-1:0]                cpu_req_addr,
    input  logic [DATA_WIDTH-1:0]                cpu_req_wdata,
    output logic                                 cpu_req_ready,
    output logic                                 cpu_resp_valid,
    output logic [DATA_WIDTH-1:0]                cpu_resp_rdata,
    output logic                                 cpu_resp_err,
    output logic                                 cpu_hit,
    output logic                                 cpu_miss,
    output logic [ADDR_WIDTH-1:0]                lo_addr,
    output logic                                 lo_rd_req,
    input  logic                                 lo_rd_valid,
    input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] lo_rd_data,
    output logic                                 lo_wb_req,
    output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] lo_wb_data,
    input  logic                                 lo_wb_ack
);
    localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W  = $clog2(NUM_SETS);
    localparam int unsigned TAG_W  = ADDR_WIDTH - PROC_ID_WIDTH - IDX_W - OFF_W;
    localparam int unsigned LINE_W = DATA_WIDTH * WORDS_PER_LINE;
    localparam int unsigned WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int unsigned AGE_W  = WAY_W;

    typedef enum logic [2:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE, ERROR_RESP} state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;
    logic                  req_write_q;
    logic [WAY_W-1:0]      victim_q;

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0]   data_q  [NUM_SETS][NUM_WAYS];
    logic [AGE_W-1:0]    age_q   [NUM_SETS][NUM_WAYS];

    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [OFF_W-1:0]      req_off;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic [WAY_W-1:0]      victim;
    logic [LINE_W-1:0]     hit_line;
    logic [DATA_WIDTH-1:0] hit_word;

    assign req_tag  = req_addr_q[OFF_W+IDX_W +: TAG_W];
    assign req_idx  = req_addr_q[OFF_W +: IDX_W];
    assign req_off  = req_addr_q[OFF_W-1:0];
    assign hit_line = data_q[req_idx][hit_way];
    assign hit_word = hit_line[DATA_WIDTH*int'(req_off) +: DATA_WIDTH];

    // Tag match across the ways of the addressed set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest invalid way wins over the oldest way (descending scan, last write wins)
    always_comb begin
        victim = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (age_q[req_idx][w] == AGE_W'(NUM_WAYS - 1)) victim = WAY_W'(w);
        end
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) victim = WAY_W'(w);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cpu_req_valid) begin
                    if (cpu_req_addr[ADDR_WIDTH-1 -: PROC_ID_WIDTH] == PROC_ID_WIDTH'(PROC_ID))
                        state_d = COMPARE;
                    else
                        state_d = ERROR_RESP;
                end
            end
            COMPARE: begin
                if (hit)
                    state_d = IDLE;
                else if (valid_q[req_idx][victim] && dirty_q[req_idx][victim])
                    state_d = WRITE_BACK;
                else
                    state_d = ALLOCATE;
            end
            WRITE_BACK: if (lo_wb_ack)   state_d = ALLOCATE;
            ALLOCATE:   if (lo_rd_valid) state_d = COMPARE;
            ERROR_RESP: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Outputs decode from the registered state and arrays only
    always_comb begin
        cpu_req_ready  = (state_q == IDLE);
        cpu_resp_valid = 1'b0;
        cpu_resp_rdata = '0;
        cpu_resp_err   = 1'b0;
        cpu_hit        = 1'b0;
        cpu_miss       = 1'b0;
        lo_addr        = '0;
        lo_rd_req      = 1'b0;
        lo_wb_req      = 1'b0;
        lo_wb_data     = '0;
        case (state_q)
            COMPARE: begin
                if (hit) begin
                    cpu_hit        = 1'b1;
                    cpu_resp_valid = 1'b1;
                    if (!req_write_q) cpu_resp_rdata = hit_word;
                end else begin
                    cpu_miss = 1'b1;
                end
            end
            WRITE_BACK: begin
                lo_wb_req  = 1'b1;
                lo_addr    = {PROC_ID_WIDTH'(PROC_ID), tag_q[req_idx][victim_q], req_idx, OFF_W'(0)};
                lo_wb_data = data_q[req_idx][victim_q];
            end
            ALLOCATE: begin
                lo_rd_req = 1'b1;
                lo_addr   = {req_addr_q[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
            end
            ERROR_RESP: begin
                cpu_resp_valid = 1'b1;
                cpu_resp_err   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_write_q <= 1'b0;
            victim_q    <= '0;
        end else begin
            if (state_q == IDLE && cpu_req_valid) begin
                req_addr_q  <= cpu_req_addr;
                req_wdata_q <= cpu_req_wdata;
                req_write_q <= cpu_req_write;
            end
            if (state_q == COMPARE && !hit) victim_q <= victim;
        end
    end

    // Cache arrays: hit updates (ages, write merge), write-back clean, line fill
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    data_q[s][w] <= '0;
                    age_q[s][w]  <= AGE_W'(w);
                end
            end
        end else begin
            case (state_q)
                COMPARE: begin
                    if (hit) begin
                        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                            if (WAY_W'(w) == hit_way)
                                age_q[req_idx][w] <= '0;
                            else if (age_q[req_idx][w] < age_q[req_idx][hit_way])
                                age_q[req_idx][w] <= age_q[req_idx][w] + AGE_W'(1);
                        end
                        if (req_write_q) begin
                            data_q[req_idx][hit_way][DATA_WIDTH*int'(req_off) +: DATA_WIDTH] <= req_wdata_q;
                            dirty_q[req_idx][hit_way] <= 1'b1;
                        end
                    end
                end
                WRITE_BACK: begin
                    if (lo_wb_ack) dirty_q[req_idx][victim_q] <= 1'b0;
                end
                ALLOCATE: begin
                    if (lo_rd_valid) begin
                        data_q[req_idx][victim_q]  <= lo_rd_data;
                        tag_q[req_idx][victim_q]   <= req_tag;
                        valid_q[req_idx][victim_q] <= 1'b1;
                        dirty_q[req_idx][victim_q] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_ctrl_l1_assoc.sv
// Directed bench: 2-way instance for fill/hit/write-back/error/reset, 4-way instance for LRU order.
module tb_cache_ctrl_l1_assoc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         sel;
    logic         req_valid, req_write;
    logic [31:0]  req_addr, req_wdata;
    logic         rd_valid, wb_ack;
    logic [127:0] rd_data;

    logic [1:0]         ready, resp_valid, resp_err, hit_o, miss_o, rd_req, wb_req;
    logic [1:0][31:0]   rdata_o, lo_addr_o;
    logic [1:0][127:0]  wb_data_o;

    cache_ctrl_l1_assoc dut (
        .clk(clk), .reset(reset),
        .cpu_req_valid(req_valid & ~sel), .cpu_req_write(req_write),
        .cpu_req_addr(req_addr), .cpu_req_wdata(req_wdata),
        .cpu_req_ready(ready[0]), .cpu_resp_valid(resp_valid[0]),
        .cpu_resp_rdata(rdata_o[0]), .cpu_resp_err(resp_err[0]),
        .cpu_hit(hit_o[0]), .cpu_miss(miss_o[0]),
        .lo_addr(lo_addr_o[0]), .lo_rd_req(rd_req[0]), .lo_rd_valid(rd_valid & ~sel),
        .lo_rd_data(rd_data), .lo_wb_req(wb_req[0]), .lo_wb_data(wb_data_o[0]),
        .lo_wb_ack(wb_ack & ~sel)
    );

    cache_ctrl_l1_assoc #(.NUM_WAYS(4)) dut4 (
        .clk(clk), .reset(reset),
        .cpu_req_valid(req_valid & sel), .cpu_req_write(req_write),
        .cpu_req_addr(req_addr), .cpu_req_wdata(req_wdata),
        .cpu_req_ready(ready[1]), .cpu_resp_valid(resp_valid[1]),
        .cpu_resp_rdata(rdata_o[1]), .cpu_resp_err(resp_err[1]),
        .cpu_hit(hit_o[1]), .cpu_miss(miss_o[1]),
        .lo_addr(lo_addr_o[1]), .lo_rd_req(rd_req[1]), .lo_rd_valid(rd_valid & sel),
        .lo_rd_data(rd_data), .lo_wb_req(wb_req[1]), .lo_wb_data(wb_data_o[1]),
        .lo_wb_ack(wb_ack & sel)
    );

    typedef struct {
        bit           sel;
        bit           wr;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [127:0] fill;
        bit           miss;
        bit           wb;
        logic [31:0]  wb_addr;
        logic [31:0]  wb_word;
        int           wb_off;
        bit           err;
        logic [31:0]  rdata;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];

    task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (vec %0d): got %h, want %h", nm, n, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_line(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    function automatic vec_t mk_vec(input bit s, input bit wr, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [127:0] fill,
                                    input bit miss, input bit wb, input logic [31:0] wb_addr,
                                    input logic [31:0] wb_word, input int wb_off,
                                    input bit err, input logic [31:0] rdata);
        vec_t v;
        v.sel = s; v.wr = wr; v.addr = addr; v.wdata = wdata; v.fill = fill;
        v.miss = miss; v.wb = wb; v.wb_addr = wb_addr; v.wb_word = wb_word;
        v.wb_off = wb_off; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    // Issue one request, play the lower-level memory, and check the whole transaction
    task automatic run_vec(input vec_t v, input int n);
        int lat = 0, misses = 0, both = 0, waits = 0;
        bit saw_resp = 0, saw_wb = 0, saw_rd = 0, wb_first = 0, h = 0, e = 0;
        logic [31:0] wb_a = '0, wb_w = '0, rd_a = '0, rdat = '0;
        sel = v.sel;
        @(negedge clk);
        while (!ready[sel] && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        chk("ready", n, 32'(ready[sel]), 32'd1);
        req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 60 && !saw_resp; c++) begin
            @(negedge clk);
            if (miss_o[sel]) misses++;
            if (rd_req[sel] && wb_req[sel]) both++;
            if (wb_req[sel] && !saw_wb) begin
                saw_wb = 1; wb_a = lo_addr_o[sel]; wb_w = wb_data_o[sel][v.wb_off*32 +: 32];
            end
            if (rd_req[sel] && !saw_rd) begin
                saw_rd = 1; rd_a = lo_addr_o[sel]; wb_first = saw_wb;
            end
            wb_ack   = wb_req[sel];
            rd_valid = rd_req[sel];
            rd_data  = rd_req[sel] ? v.fill : '0;
            if (resp_valid[sel]) begin
                saw_resp = 1; lat = c; h = hit_o[sel]; e = resp_err[sel]; rdat = rdata_o[sel];
            end
        end
        wb_ack = 1'b0; rd_valid = 1'b0; rd_data = '0;
        chk("resp_seen", n, 32'(saw_resp), 32'd1);
        chk("miss_pulses", n, 32'(misses), 32'(v.miss));
        chk("wb_req", n, 32'(saw_wb), 32'(v.wb));
        if (v.wb) begin
            chk("wb_addr", n, wb_a, v.wb_addr);
            chk("wb_word", n, wb_w, v.wb_word);
        end
        chk("rd_req", n, 32'(saw_rd), 32'(v.miss));
        if (v.miss) begin
            chk("rd_addr", n, rd_a, {v.addr[31:2], 2'b00});
            chk("wb_before_rd", n, 32'(wb_first), 32'(v.wb));
        end
        chk("rd_wb_overlap", n, 32'(both), 32'd0);
        chk("hit", n, 32'(h), 32'(!v.err));
        chk("err", n, 32'(e), 32'(v.err));
        if (!v.wr) chk("rdata", n, rdat, v.rdata);
        if (!v.miss) chk("latency", n, 32'(lat), 32'd1);
    endtask

    initial begin
        reset = 1'b0; sel = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rd_valid = 1'b0; wb_ack = 1'b0; rd_data = '0;

        // 2-way: set 4 holds tags 0 (0x10), 1 (0x50), 2 (0x90)
        vecs.push_back(mk_vec(0, 0, 32'h10, 0, mk_line(32'h1), 1, 0, 0, 0, 0, 0, 32'h1));
        vecs.push_back(mk_vec(0, 0, 32'h12, 0, '0, 0, 0, 0, 0, 0, 0, 32'h3));
        vecs.push_back(mk_vec(0, 1, 32'h11, 32'hDEADBEEF, '0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk_vec(0, 0, 32'h50, 0, mk_line(32'h11), 1, 0, 0, 0, 0, 0, 32'h11));
        vecs.push_back(mk_vec(0, 0, 32'h90, 0, mk_line(32'h21), 1, 1, 32'h10, 32'hDEADBEEF, 1, 0, 32'h21));
        vecs.push_back(mk_vec(0, 0, 32'h11, 0, {32'h4, 32'h3, 32'hDEADBEEF, 32'h1}, 1, 0, 0, 0, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk_vec(0, 0, 32'h4000_0010, 0, '0, 0, 0, 0, 0, 0, 1, 32'h0));
        vecs.push_back(mk_vec(0, 0, 32'h12, 0, '0, 0, 0, 0, 0, 0, 0, 32'h3));
        vecs.push_back(mk_vec(0, 0, 32'h93, 0, '0, 0, 0, 0, 0, 0, 0, 32'h24));
        // 4-way: A,B,C,D,A then E evicts B
        vecs.push_back(mk_vec(1, 0, 32'h10,  0, mk_line(32'hA0), 1, 0, 0, 0, 0, 0, 32'hA0));
        vecs.push_back(mk_vec(1, 0, 32'h50,  0, mk_line(32'hB0), 1, 0, 0, 0, 0, 0, 32'hB0));
        vecs.push_back(mk_vec(1, 0, 32'h90,  0, mk_line(32'hC0), 1, 0, 0, 0, 0, 0, 32'hC0));
        vecs.push_back(mk_vec(1, 0, 32'hD0,  0, mk_line(32'hD0), 1, 0, 0, 0, 0, 0, 32'hD0));
        vecs.push_back(mk_vec(1, 0, 32'h11,  0, '0, 0, 0, 0, 0, 0, 0, 32'hA1));
        vecs.push_back(mk_vec(1, 0, 32'h110, 0, mk_line(32'hE0), 1, 0, 0, 0, 0, 0, 32'hE0));
        vecs.push_back(mk_vec(1, 0, 32'h12,  0, '0, 0, 0, 0, 0, 0, 0, 32'hA2));
        vecs.push_back(mk_vec(1, 0, 32'h93,  0, '0, 0, 0, 0, 0, 0, 0, 32'hC3));
        vecs.push_back(mk_vec(1, 0, 32'hD1,  0, '0, 0, 0, 0, 0, 0, 0, 32'hD1));
        vecs.push_back(mk_vec(1, 0, 32'h50,  0, mk_line(32'hB0), 1, 0, 0, 0, 0, 0, 32'hB0));

        #1;
        chk("rst_ready", -1, 32'(ready[0]), 32'd1);
        chk("rst_resp_valid", -1, 32'(resp_valid[0]), 32'd0);
        chk("rst_hit_miss", -1, 32'({hit_o[0], miss_o[0], resp_err[0]}), 32'd0);
        chk("rst_lo_req", -1, 32'({rd_req[0], wb_req[0]}), 32'd0);
        chk("rst_lo_addr", -1, lo_addr_o[0], 32'd0);
        chk("rst_rdata", -1, rdata_o[0], 32'd0);
        chk("rst_wb_data", -1, 32'(|wb_data_o[0]), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        // Stray lower-level handshakes in IDLE must be ignored
        rd_valid = 1'b1; wb_ack = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ignore_ready", -2, 32'(ready[0]), 32'd1);
        chk("idle_ignore_resp", -2, 32'(resp_valid[0]), 32'd0);
        rd_valid = 1'b0; wb_ack = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Reset during ALLOCATE with the fill arriving in the same cycle
        begin
            bit seen = 0;
            sel = 1'b0;
            @(negedge clk);
            req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h150; req_wdata = '0;
            @(posedge clk);
            #1 req_valid = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                if (rd_req[0]) seen = 1;
            end
            chk("abort_rd_req_seen", -3, 32'(seen), 32'd1);
            rd_valid = 1'b1; rd_data = mk_line(32'h55); reset = 1'b0;
            #1;
            chk("abort_rd_req_drop", -3, 32'(rd_req[0]), 32'd0);
            chk("abort_ready", -3, 32'(ready[0]), 32'd1);
            chk("abort_lo_addr", -3, lo_addr_o[0], 32'd0);
            @(posedge clk);
            @(negedge clk);
            rd_valid = 1'b0; rd_data = '0; reset = 1'b1;
        end
        run_vec(mk_vec(0, 0, 32'h150, 0, mk_line(32'h55), 1, 0, 0, 0, 0, 0, 32'h55), 100);
        run_vec(mk_vec(0, 0, 32'h12, 0, mk_line(32'h1), 1, 0, 0, 0, 0, 0, 32'h3), 101);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
